// File: rtl/servo_pulse_capture_if.sv
// Result bus of the servo pulse capture block.
//   pulse_width   : last captured high time, in ticks
//   period        : last captured rising-to-rising period, in ticks
//   capture_valid : one-cycle strobe on the cycle pulse_width/period update
//   signal_lost   : sticky timeout flag, cleared by the next capture
//   pwm_level     : synchronized input level, for debug
// master = the capture block (drives), slave = the consumer (reads).
interface servo_pulse_capture_if #(
  parameter int W = 16
);
  logic [W-1:0] pulse_width;
  logic [W-1:0] period;
  logic         capture_valid;
  logic         signal_lost;
  logic         pwm_level;

  modport master (output pulse_width, period, capture_valid, signal_lost, pwm_level);
  modport slave  (input  pulse_width, period, capture_valid, signal_lost, pwm_level);
endinterface

// File: rtl/servo_pulse_capture.sv
// Servo PWM decoder: measures high time and rising-to-rising period of an
// asynchronous PWM input in prescaled ticks and presents them as held
// registers with a one-cycle capture strobe.
//   clk25mhz : system clock, rising edge
//   reset    : asynchronous, active-low
//   pwm_in   : raw PWM input (asynchronous)
//   cap      : result bus (master side), see servo_pulse_capture_if
module servo_pulse_capture #(
  parameter int PRESCALE      = 25,
  parameter int W             = 16,
  parameter int TIMEOUT_TICKS = 50000
) (
  input  logic                  clk25mhz,
  input  logic                  reset,
  input  logic                  pwm_in,
  servo_pulse_capture_if.master cap
);

  localparam int           PW       = $clog2(PRESCALE);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [W-1:0]  CNT_MAX  = '1;
  localparam logic [W-1:0]  TO_LIM   = W'(TIMEOUT_TICKS);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t        state, state_nxt;
  logic          s1, s2, s3;
  logic [1:0]    vld_pipe;
  logic          armed;
  logic [PW-1:0] pre_cnt;
  logic [W-1:0]  hi_cnt, per_cnt, hi_inc, per_inc;
  logic          rise, fall, tick, per_at_lim;
  logic          do_capture, timeout_hit, cnt_clr, hi_en, per_en;

  // Synchronizer plus edge-history flop.
  always_ff @(posedge clk25mhz or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= pwm_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // s2 is forced low by reset, so a level already high at release would look
  // like a rise. Only accept rises once s2 has carried a real sampled low.
  always_ff @(posedge clk25mhz or negedge reset) begin
    if (!reset) begin
      vld_pipe <= '0;
      armed    <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[0], 1'b1};
      armed    <= armed | (vld_pipe[1] & ~s2);
    end
  end

  assign rise = s2 & ~s3 & armed;
  assign fall = ~s2 & s3;
  assign tick = (pre_cnt == PRE_LAST);

  // Restarting the prescaler after a rise makes tick j of a period land on
  // clock j*PRESCALE+1, so counting the tick of the closing edge's own cycle
  // yields floor(clocks/PRESCALE) exactly.
  always_ff @(posedge clk25mhz or negedge reset) begin
    if (!reset)    pre_cnt <= '0;
    else if (rise) pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else           pre_cnt <= pre_cnt + PW'(1);
  end

  // Saturating next values; the capture takes per_inc so the tick coinciding
  // with the closing rise is included.
  assign hi_inc     = (tick && hi_cnt  != CNT_MAX) ? hi_cnt  + W'(1) : hi_cnt;
  assign per_inc    = (tick && per_cnt != CNT_MAX) ? per_cnt + W'(1) : per_cnt;
  assign per_at_lim = (per_inc == TO_LIM);

  always_ff @(posedge clk25mhz or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (rise) state_nxt = HIGH;
      HIGH:    if (per_at_lim) state_nxt = IDLE;
               else if (fall) state_nxt = LOW;
      LOW:     if (rise) state_nxt = HIGH;      // rise beats a same-cycle timeout
               else if (per_at_lim) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    do_capture  = (state == LOW) && rise;
    timeout_hit = (state == HIGH || state == LOW) && per_at_lim && !do_capture;
    hi_en       = (state == HIGH);
    per_en      = (state == HIGH || state == LOW);
    cnt_clr     = (state == IDLE) || do_capture || timeout_hit;
  end

  always_ff @(posedge clk25mhz or negedge reset) begin
    if (!reset) begin
      hi_cnt  <= '0;
      per_cnt <= '0;
    end else if (cnt_clr) begin
      hi_cnt  <= '0;
      per_cnt <= '0;
    end else begin
      if (hi_en)  hi_cnt  <= hi_inc;
      if (per_en) per_cnt <= per_inc;
    end
  end

  always_ff @(posedge clk25mhz or negedge reset) begin
    if (!reset) begin
      cap.pulse_width   <= '0;
      cap.period        <= '0;
      cap.capture_valid <= 1'b0;
      cap.signal_lost   <= 1'b0;
    end else begin
      cap.capture_valid <= do_capture;
      if (do_capture) begin
        cap.pulse_width <= hi_cnt;
        cap.period      <= per_inc;
        cap.signal_lost <= 1'b0;
      end else if (timeout_hit) begin
        cap.signal_lost <= 1'b1;
      end
    end
  end

  assign cap.pwm_level = s2;

endmodule
